// File: rtl/nearest_hit_select_if.sv
// Candidate-beat / per-ray result bundle for nearest_hit_select.
// The backface_in signal exists only when NEAREST_HIT_BACKFACE_EN is defined.
interface nearest_hit_select_if #(
  parameter int D_WIDTH  = 32,
  parameter int ID_WIDTH = 16
);
  logic                valid_in;
  logic [D_WIDTH-1:0]  t_in;
  logic                hit_in;
  logic [ID_WIDTH-1:0] id_in;
  logic                last_in;
`ifdef NEAREST_HIT_BACKFACE_EN
  logic                backface_in;
`endif
  logic                valid_out;
  logic                hit_out;
  logic [D_WIDTH-1:0]  t_out;
  logic [ID_WIDTH-1:0] id_out;
  logic [ID_WIDTH-1:0] tri_count;

  modport master (
    output valid_in, t_in, hit_in, id_in, last_in,
`ifdef NEAREST_HIT_BACKFACE_EN
    output backface_in,
`endif
    input  valid_out, hit_out, t_out, id_out, tri_count
  );

  modport slave (
    input  valid_in, t_in, hit_in, id_in, last_in,
`ifdef NEAREST_HIT_BACKFACE_EN
    input  backface_in,
`endif
    output valid_out, hit_out, t_out, id_out, tri_count
  );
endinterface

// File: rtl/nearest_hit_select.sv
// Nearest-hit reduction over one ray's triangle candidates; one result pulse per ray.
// Optional backface culling via NEAREST_HIT_BACKFACE_EN.
module nearest_hit_select #(
  parameter int Q_BITS   = 10,
  parameter int D_WIDTH  = 32,
  parameter int ID_WIDTH = 16,
  parameter int T_MIN    = 1
) (
  input  logic                clock,
  input  logic                reset,
  nearest_hit_select_if.slave bus
);
  if (Q_BITS < 0 || Q_BITS >= D_WIDTH) begin : g_bad_q
    $error("nearest_hit_select: Q_BITS must lie in [0, D_WIDTH)");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

  localparam logic signed [D_WIDTH-1:0] T_MAX   = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH-1:0] T_LO    = D_WIDTH'(T_MIN);
  localparam logic [ID_WIDTH-1:0]       CNT_MAX = '1;

  state_t                     r_state, w_state_nxt;
  logic signed [D_WIDTH-1:0]  r_best_t, w_best_t_nxt;
  logic [ID_WIDTH-1:0]        r_best_id, w_best_id_nxt;
  logic                       r_best_hit, w_best_hit_nxt;
  logic [ID_WIDTH-1:0]        r_cnt, w_cnt_nxt;
  logic                       r_hit_out;
  logic [D_WIDTH-1:0]         r_t_out;
  logic [ID_WIDTH-1:0]        r_id_out, r_cnt_out;

  logic signed [D_WIDTH-1:0]  w_t_s;
  logic                       w_facing, w_accept;

  assign w_t_s = bus.t_in;

`ifdef NEAREST_HIT_BACKFACE_EN
  assign w_facing = ~bus.backface_in;
`else
  assign w_facing = 1'b1;
`endif

  // Saturated t is a divide-by-zero marker, never a real hit; strict < keeps the earlier id on ties.
  assign w_accept = bus.valid_in && bus.hit_in && w_facing &&
                    (w_t_s >= T_LO) && (w_t_s != T_MAX) && (w_t_s < r_best_t);

  always_comb begin
    w_best_t_nxt   = r_best_t;
    w_best_id_nxt  = r_best_id;
    w_best_hit_nxt = r_best_hit;
    w_cnt_nxt      = r_cnt;
    if (w_accept) begin
      w_best_t_nxt   = w_t_s;
      w_best_id_nxt  = bus.id_in;
      w_best_hit_nxt = 1'b1;
    end
    if (bus.valid_in && r_cnt != CNT_MAX)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (bus.valid_in) w_state_nxt = bus.last_in ? S_EMIT : S_ACCUM;
      end
      S_EMIT: begin
        if (bus.valid_in) w_state_nxt = bus.last_in ? S_EMIT : S_ACCUM;
        else              w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The last beat's merged result goes straight to the output registers while the
  // accumulators restart, so the EMIT cycle can take the next ray's first beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_best_t   <= T_MAX;
      r_best_id  <= '0;
      r_best_hit <= 1'b0;
      r_cnt      <= '0;
      r_hit_out  <= 1'b0;
      r_t_out    <= T_MAX;
      r_id_out   <= '0;
      r_cnt_out  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.valid_in) begin
        if (bus.last_in) begin
          r_hit_out  <= w_best_hit_nxt;
          r_t_out    <= w_best_t_nxt;
          r_id_out   <= w_best_id_nxt;
          r_cnt_out  <= w_cnt_nxt;
          r_best_t   <= T_MAX;
          r_best_id  <= '0;
          r_best_hit <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_best_t   <= w_best_t_nxt;
          r_best_id  <= w_best_id_nxt;
          r_best_hit <= w_best_hit_nxt;
          r_cnt      <= w_cnt_nxt;
        end
      end
    end
  end

  assign bus.valid_out = (r_state == S_EMIT);
  assign bus.hit_out   = r_hit_out;
  assign bus.t_out     = r_t_out;
  assign bus.id_out    = r_id_out;
  assign bus.tri_count = r_cnt_out;
endmodule

// File: tb/tb_nearest_hit_select.sv
// Directed bench for nearest_hit_select: per-ray reference model plus literal expectations.
module tb_nearest_hit_select;
  localparam int DW   = 32;
  localparam int IW   = 16;
  localparam int TMIN = 1;
  localparam logic [DW-1:0] TMAX = 32'h7FFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  nearest_hit_select_if #(.D_WIDTH(DW), .ID_WIDTH(IW)) bus();
  nearest_hit_select #(.Q_BITS(10), .D_WIDTH(DW), .ID_WIDTH(IW), .T_MIN(TMIN)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] t;
    logic          hit;
    logic [IW-1:0] id;
    logic          bf;
  } beat_t;

  typedef struct {
    int            due;
    logic          hit;
    logic [DW-1:0] t;
    logic [IW-1:0] id;
    logic [IW-1:0] cnt;
  } res_t;

  beat_t ray[$];
  res_t  expq[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Nearest accepted candidate over the whole ray, scanning in arrival order.
  function automatic res_t model(input int due);
    res_t r;
    logic signed [DW-1:0] best, tv;
    best  = TMAX;
    r.due = due;
    r.hit = 1'b0;
    r.id  = '0;
    foreach (ray[i]) begin
      tv = ray[i].t;
      if (ray[i].hit && !ray[i].bf && tv >= TMIN && tv != $signed(TMAX) && tv < best) begin
        best  = tv;
        r.id  = ray[i].id;
        r.hit = 1'b1;
      end
    end
    r.t   = best;
    r.cnt = (ray.size() > 65535) ? 16'hFFFF : IW'(ray.size());
    return r;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        res_t r;
        r = expq.pop_front();
        check("pulse_valid", bus.valid_out, 1'b1);
        check("pulse_hit",   bus.hit_out,   r.hit);
        check("pulse_t",     bus.t_out,     r.t);
        check("pulse_id",    bus.id_out,    r.id);
        check("pulse_cnt",   bus.tri_count, r.cnt);
      end else begin
        check("no_pulse", bus.valid_out, 1'b0);
      end
    end
  end

  task automatic beat(input logic [DW-1:0] t, input logic hit, input logic [IW-1:0] id,
                      input logic last, input logic bf = 1'b0);
    beat_t b;
    @(negedge clock);
    bus.valid_in = 1'b1;
    bus.t_in     = t;
    bus.hit_in   = hit;
    bus.id_in    = id;
    bus.last_in  = last;
    b.t   = t;
    b.hit = hit;
    b.id  = id;
`ifdef NEAREST_HIT_BACKFACE_EN
    bus.backface_in = bf;
    b.bf  = bf;
`else
    b.bf  = 1'b0;
`endif
    ray.push_back(b);
    if (last) begin
      expq.push_back(model(cyc + 1));
      ray.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
    end
  endtask

  task automatic lit(input string name, input logic hit, input logic [DW-1:0] t,
                     input logic [IW-1:0] id, input logic [IW-1:0] cnt);
    check({name, "_hit"}, bus.hit_out,   hit);
    check({name, "_t"},   bus.t_out,     t);
    check({name, "_id"},  bus.id_out,    id);
    check({name, "_cnt"}, bus.tri_count, cnt);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.t_in     = '0;
    bus.hit_in   = 1'b0;
    bus.id_in    = '0;
    bus.last_in  = 1'b0;
`ifdef NEAREST_HIT_BACKFACE_EN
    bus.backface_in = 1'b0;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_valid", bus.valid_out, 1'b0);
    lit("rst", 1'b0, TMAX, 16'd0, 16'd0);
    reset = 1'b0;
    idle(1);

    // Nearest of three hits
    beat(32'd27794, 1'b1, 16'd3, 1'b0);
    beat(32'd10240, 1'b1, 16'd4, 1'b0);
    beat(32'd51200, 1'b1, 16'd5, 1'b1);
    idle(2);
    lit("near", 1'b1, 32'd10240, 16'd4, 16'd3);

    // Negative, zero and non-hit candidates -> miss
    beat(32'hFFFF_FC00, 1'b1, 16'd10, 1'b0);
    beat(32'd0,         1'b1, 16'd11, 1'b0);
    beat(32'd20480,     1'b0, 16'd12, 1'b1);
    idle(2);
    lit("miss", 1'b0, TMAX, 16'd0, 16'd3);

    // Equal t keeps the earlier id
    beat(32'd5120, 1'b1, 16'd7, 1'b0);
    beat(32'd5120, 1'b1, 16'd8, 1'b1);
    idle(2);
    lit("tie", 1'b1, 32'd5120, 16'd7, 16'd2);

    // Back-to-back rays, single-beat ray A then ray B
    beat(32'd2048, 1'b1, 16'd1, 1'b1);
    beat(32'd1024, 1'b1, 16'd2, 1'b0);
    check("b2b_a_valid", bus.valid_out, 1'b1);
    lit("b2b_a", 1'b1, 32'd2048, 16'd1, 16'd1);
    beat(32'd4096, 1'b1, 16'd3, 1'b1);
    idle(2);
    lit("b2b_b", 1'b1, 32'd1024, 16'd2, 16'd2);

    // Reset mid-ray discards the partial ray
    beat(32'd600, 1'b1, 16'd20, 1'b0);
    beat(32'd700, 1'b1, 16'd21, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    bus.valid_in = 1'b0;
    ray.delete();
    @(negedge clock);
    reset = 1'b0;
    beat(32'd3072, 1'b1, 16'd9, 1'b1);
    idle(2);
    lit("after_rst", 1'b1, 32'd3072, 16'd9, 16'd1);

    // Saturated t rejected, T_MIN accepted, bubble inside the ray
    beat(TMAX, 1'b1, 16'd1, 1'b0);
    idle(1);
    beat(32'd1, 1'b1, 16'd2, 1'b0);
    beat(32'd2, 1'b1, 16'd3, 1'b1);
    idle(2);
    lit("tmin", 1'b1, 32'd1, 16'd2, 16'd3);

    beat(TMAX, 1'b1, 16'd5, 1'b1);
    idle(2);
    lit("sat", 1'b0, TMAX, 16'd0, 16'd1);

    // Facing: culled only when the optional feature is built in
    beat(32'd1024, 1'b1, 16'd30, 1'b0, 1'b1);
    beat(32'd2048, 1'b1, 16'd31, 1'b1, 1'b0);
    idle(2);
`ifdef NEAREST_HIT_BACKFACE_EN
    lit("backface", 1'b1, 32'd2048, 16'd31, 16'd2);
`else
    lit("backface", 1'b1, 32'd1024, 16'd30, 16'd2);
`endif

    idle(3);
    check("pending_results", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nearest_hit_select.md
Name: nearest_hit_select

Overview:
- Sits directly downstream of the fixed-point divide stage in the ray-triangle intersection path.
- Consumes one candidate distance t (the divide quotient) per triangle, qualified by a hit flag from the barycentric tests.
- Tracks the nearest valid hit across all triangles of one ray, then emits a single result per ray: hit/miss, t, triangle id.
- Downstream shading consumes that result.

Parameters:
- Q_BITS, 10, fractional bits of the signed fixed-point t.
- D_WIDTH, 32, width of t in bits.
- ID_WIDTH, 16, width of the triangle id and of the per-ray counter.
- T_MIN, 1, minimum accepted t in raw Q units (1 = 2^-Q_BITS); rejects self-intersection.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  candidate beat valid; one beat per cycle max, no backpressure.
- t_in  in  D_WIDTH  signed Q(D_WIDTH-Q_BITS).Q_BITS distance from divide quotient.
- hit_in  in  1  1 = triangle passed the inside test.
- id_in  in  ID_WIDTH  triangle id of this beat.
- last_in  in  1  marks the final triangle of the current ray; sampled only with valid_in.
- valid_out  out  1  one-cycle pulse: result for one ray.
- hit_out  out  1  1 = at least one candidate accepted for the ray.
- t_out  out  D_WIDTH  nearest accepted t; 2^(D_WIDTH-1)-1 on miss.
- id_out  out  ID_WIDTH  id of the nearest hit; 0 on miss.
- tri_count  out  ID_WIDTH  number of beats consumed for the ray, including the last.

Behaviour:
- Reset values: valid_out=0, hit_out=0, t_out=max positive (0x7FFFFFFF at defaults), id_out=0, tri_count=0.
- Reset also clears internal best_t to max positive, best_id=0, best_hit=0, cnt=0, and state to IDLE.
- Reset mid-ray discards all partial state; no valid_out for that ray.
- Accept rule for a beat: hit_in=1 AND t_in >= T_MIN (signed compare; negative t rejected) AND t_in < best_t (strict).
- Ties keep the earlier id.
- t_in = max positive is treated as a divide-by-zero saturation and rejected.
- State machine:
  - IDLE: no beat yet for the current ray.
  - ACCUM: at least one beat seen, last not yet seen.
  - IDLE/ACCUM on a valid beat with last_in=0 -> ACCUM, update best and cnt.
  - On a valid beat with last_in=1 -> EMIT.
  - EMIT: valid_out=1 for exactly this one cycle. Outputs reflect the merged result, including the last beat, so the last beat's own candidate competes. Best and cnt are reset for the next ray in the same cycle.
  - In EMIT, a new valid beat is accepted as the first beat of the next ray, so back-to-back rays run at full throughput. Next state is ACCUM, or EMIT again if that beat also has last_in=1.
  - EMIT with no valid beat -> IDLE.
- Latency: valid_out rises exactly 1 cycle after the last_in beat is sampled.
- A single-beat ray (last_in=1 on the first beat) is legal.
- Outputs hold their values after the pulse until the next EMIT.
- cnt saturates at 2^ID_WIDTH-1; no wrap.
- valid_in=0 cycles inside a ray are bubbles: no state change.

Optional Feature:
- Macro NEAREST_HIT_BACKFACE_EN.
- When defined: adds input backface_in (1 bit, sampled with valid_in). A beat with backface_in=1 is rejected even when hit_in=1 (backface culling).
- When undefined: the port does not exist and facing is ignored.

Test Plan:
- Reset pulse, then beats t={27794 (190/7 Q10), 10240, 51200}, hit all 1, ids {3,4,5}, last on the third -> 1 cycle later: valid_out=1, hit_out=1, t_out=10240, id_out=4, tri_count=3.
- Beats t={-1024, 0, 20480}, hit={1,1,0}, last on the third -> miss: hit_out=0, t_out=0x7FFFFFFF, id_out=0, tri_count=3.
- Tie: t={5120, 5120}, ids {7,8} -> id_out=7, t_out=5120.
- Back-to-back: ray A is a single last beat (t=2048, id 1); the next cycle starts ray B = {t=1024 id 2, last t=4096 id 3} -> two pulses: (2048, 1) then (1024, 2), B with tri_count=2.
- Reset asserted after 2 beats of a ray, then a fresh 1-beat ray (t=3072, id 9, last) -> exactly one pulse with t_out=3072, id_out=9, tri_count=1.
- With NEAREST_HIT_BACKFACE_EN: t={1024 back=1, 2048 back=0} -> t_out=2048. Without the macro, the same beats minus backface_in -> t_out=1024.
